// File: rtl/stack_pkg.sv
// stack_pkg: shared defaults, opcode and FSM state enums for the stack controller
package stack_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF = 256;
  typedef enum logic [2:0] {OP_NOP, OP_PUSH, OP_POP, OP_PEEK, OP_DUP, OP_SWAP, OP_DROP, OP_RSVD} op_e;
  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_e;
endpackage

// File: rtl/stack_ram.sv
// stack_ram: single-port stack storage, one-cycle read latency, contents survive reset
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] m [DEPTH];
  always_ff @(posedge clk) begin
    if (we) m[addr] <= wdata;
    rdata <= m[addr];
  end
endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: command-driven stack controller over an external single-port RAM.
// Define STACK_CTRL_GUARD_EN to reject under/overflowing commands; otherwise sp wraps modulo DEPTH.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   sp,
  output logic              empty,
  output logic              full
);
  state_e state, state_n, st;
  op_e op, cop;
  logic [DATA_W-1:0] a, b;
  logic err, rej, acc;
  logic [ADDR_W:0] sp_inc, sp_dec;
  logic [ADDR_W-1:0] sp_lo, sm1, sm2;
  assign cop = op_e'(cmd_op);
  assign sp_lo = sp[ADDR_W-1:0];
  assign sm1 = sp_lo - ADDR_W'(1);
  assign sm2 = sp_lo - ADDR_W'(2);
  assign empty = sp == '0;
`ifdef STACK_CTRL_GUARD_EN
  assign full = sp[ADDR_W];
  assign sp_inc = sp + (ADDR_W+1)'(1);
  assign sp_dec = sp - (ADDR_W+1)'(1);
  assign rej = cop == OP_RSVD || (cop == OP_PUSH && full) || (cop == OP_DUP && (empty || full)) ||
               ((cop == OP_POP || cop == OP_PEEK || cop == OP_DROP) && empty) ||
               (cop == OP_SWAP && sp < (ADDR_W+1)'(2));
`else
  assign full = 1'b0;
  assign sp_inc = {1'b0, sp_lo + ADDR_W'(1)};
  assign sp_dec = {1'b0, sm1};
  assign rej = cop == OP_RSVD;
`endif
  assign acc = cmd_valid && cmd_ready;
  // outputs see IDLE while rst is high so an aborted operation emits nothing
  assign st = rst ? IDLE : state;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (acc) state_n = rej ? RESP : cop == OP_PUSH ? WR0 :
                               (cop == OP_POP || cop == OP_PEEK || cop == OP_DUP || cop == OP_SWAP) ? RD0 : RESP;
      RD0: state_n = op == OP_DUP ? WR0 : op == OP_SWAP ? RD1 : RESP;
      RD1: state_n = WR0;
      WR0: state_n = op == OP_SWAP ? WR1 : RESP;
      WR1: state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sp <= '0;
      op <= OP_NOP;
      err <= 1'b0;
      a <= '0;
      b <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        op <= cop;
        b <= cmd_data;
        err <= rej;
      end
      if (state == RD1) a <= mem_rdata;
      if (state == WR0 && op != OP_PUSH) b <= mem_rdata;
      if (state == WR0 && op != OP_SWAP) sp <= sp_inc;
      if ((state == RD0 && op == OP_POP) || (state == RESP && op == OP_DROP && !err)) sp <= sp_dec;
    end
  end
  assign cmd_ready = !rst && state == IDLE;
  assign mem_we = st == WR0 || st == WR1;
  assign mem_addr = st == RD0 ? sm1 : st == RD1 ? sm2 : st == WR0 ? (op == OP_SWAP ? sm1 : sp_lo) :
                    st == WR1 ? sm2 : '0;
  assign mem_wdata = st == WR0 ? (op == OP_PUSH ? b : mem_rdata) : st == WR1 ? a : '0;
  assign rsp_valid = st == RESP;
  assign rsp_err = rsp_valid && err;
  assign rsp_data = (!rsp_valid || err) ? '0 : (op == OP_POP || op == OP_PEEK) ? mem_rdata :
                    (op == OP_PUSH || op == OP_DUP || op == OP_SWAP) ? b : '0;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: randomized and directed checks of stack_ctrl against a transaction-level stack model
// (honours STACK_CTRL_GUARD_EN the same way as the design)
module tb_stack_ctrl;
  import stack_pkg::*;
  localparam int DW = DATA_W_DEF;
  localparam int DP = DEPTH_DEF;
  localparam int AW = $clog2(DP);
`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ready;
  logic [2:0] cmd_op = 0;
  logic [DW-1:0] cmd_data = 0, rsp_data, mem_wdata, mem_rdata;
  logic rsp_valid, rsp_err, mem_we, empty, full;
  logic [AW-1:0] mem_addr;
  logic [AW:0] sp;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  stack_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sp(sp), .empty(empty), .full(full));
  stack_ram #(.DATA_W(DW), .DEPTH(DP)) ram (
    .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // model: stack image by address, plus which addresses hold a known value
  logic [DW-1:0] mm [DP];
  bit kn [DP];
  int msp = 0;
  bit busy = 0, ee, dk, wdk1, wdk2;
  int k, lat, wk1, wk2, wa1, wa2;
  logic [DW-1:0] ed, wd1, wd2;
  logic [DW-1:0] rq_d [$];
  bit rq_e [$];

  function automatic int wrap(int x);
    return (x + 2 * DP) % DP;
  endfunction
  function automatic int inc(int s);
    return GUARD ? s + 1 : wrap(s + 1);
  endfunction
  function automatic int dec(int s);
    return GUARD ? s - 1 : wrap(s - 1);
  endfunction

  task automatic model_accept(input int op, input logic [DW-1:0] d);
    int s, t, u;
    bit rej, ka, kb;
    logic [DW-1:0] va, vb;
    s = msp; wk1 = -1; wk2 = -1; ee = 0; ed = '0; dk = 1; lat = 1;
    rej = op == 7;
    if (GUARD)
      rej = rej || (op == 1 && s == DP) || (op == 4 && (s == 0 || s == DP)) ||
            ((op == 2 || op == 3 || op == 6) && s == 0) || (op == 5 && s < 2);
    t = wrap(s - 1); u = wrap(s - 2);
    if (rej) ee = 1;
    else case (op)
      1: begin lat = 2; ed = d; wk1 = 1; wa1 = wrap(s); wd1 = d; wdk1 = 1;
               mm[wrap(s)] = d; kn[wrap(s)] = 1; msp = inc(s); end
      2, 3: begin lat = 2; ed = mm[t]; dk = kn[t]; if (op == 2) msp = dec(s); end
      4: begin lat = 3; ed = mm[t]; dk = kn[t]; wk1 = 2; wa1 = wrap(s); wd1 = ed; wdk1 = dk;
               mm[wrap(s)] = ed; kn[wrap(s)] = dk; msp = inc(s); end
      5: begin lat = 5; va = mm[t]; ka = kn[t]; vb = mm[u]; kb = kn[u];
               wk1 = 3; wa1 = t; wd1 = vb; wdk1 = kb; wk2 = 4; wa2 = u; wd2 = va; wdk2 = ka;
               mm[t] = vb; kn[t] = kb; mm[u] = va; kn[u] = ka; ed = vb; dk = kb; end
      6: msp = dec(s);
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rsp", {rsp_err, rsp_data}, 0);
      if (busy) begin
        if (wk1 >= 0) kn[wa1] = 0;
        if (wk2 >= 0) kn[wa2] = 0;
      end
      busy = 0;
      msp = 0;
    end else if (busy) begin
      k++;
      chk("busy_ready", cmd_ready, 0);
      chk("rsp_valid", rsp_valid, k == lat);
      chk("mem_we", mem_we, k == wk1 || k == wk2);
      if (k == wk1) begin
        chk("wr_addr1", mem_addr, wa1);
        if (wdk1) chk("wr_data1", mem_wdata, wd1);
      end
      if (k == wk2) begin
        chk("wr_addr2", mem_addr, wa2);
        if (wdk2) chk("wr_data2", mem_wdata, wd2);
      end
      if (k == lat) begin
        chk("rsp_err", rsp_err, ee);
        if (dk) chk("rsp_data", rsp_data, ed);
        busy = 0;
      end
    end else begin
      chk("idle_ready", cmd_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_mem_we", mem_we, 0);
      chk("sp", sp, msp);
      chk("empty", empty, msp == 0);
      chk("full", full, GUARD && msp == DP);
      if (cmd_valid) begin
        model_accept(int'(cmd_op), cmd_data);
        busy = 1;
        k = 0;
      end
    end
    if (rsp_valid) begin
      rq_d.push_back(rsp_data);
      rq_e.push_back(rsp_err);
    end
  end

  // enter at posedge+1, return at posedge+1 of the cycle after acceptance
  task automatic issue(input int op, input int d);
    int n = 0;
    cmd_valid = 1; cmd_op = op[2:0]; cmd_data = d[DW-1:0];
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 60);
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1 cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 60);
    if (!cmd_ready) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    chk("sp_after_rst", sp, 0);
    @(posedge clk); #1;
    // LIFO order
    rq_d.delete(); rq_e.delete();
    issue(1, 'h11); issue(1, 'h22); issue(1, 'h33);
    wait_idle();
    chk("sp_three", sp, 3);
    repeat (3) issue(2, 0);
    wait_idle();
    chk("sp_popped", sp, 0);
    chk("lifo_cnt", rq_d.size(), 6);
    if (rq_d.size() == 6) begin
      chk("lifo_3", rq_d[3], 'h33); chk("lifo_4", rq_d[4], 'h22); chk("lifo_5", rq_d[5], 'h11);
    end
    // DUP then SWAP
    rq_d.delete(); rq_e.delete();
    issue(1, 'hA5); issue(4, 0); issue(1, 'h5A); issue(5, 0);
    wait_idle();
    chk("swap_sp", sp, 3);
    repeat (3) issue(2, 0);
    wait_idle();
    chk("swap_cnt", rq_d.size(), 7);
    if (rq_d.size() == 7) begin
      chk("dup_rsp", rq_d[1], 'hA5); chk("swap_rsp", rq_d[3], 'hA5);
      chk("swap_pop0", rq_d[4], 'hA5); chk("swap_pop1", rq_d[5], 'h5A); chk("swap_pop2", rq_d[6], 'hA5);
    end
    // reserved opcode and NOP leave the stack alone
    rq_d.delete(); rq_e.delete();
    issue(1, 'h3C); issue(7, 'hFF); issue(0, 'h77);
    wait_idle();
    chk("rsvd_sp", sp, 1);
    if (rq_e.size() == 3) begin
      chk("rsvd_err", rq_e[1], 1); chk("rsvd_data", rq_d[1], 0); chk("nop_err", rq_e[2], 0);
    end else chk("rsvd_cnt", rq_e.size(), 3);
    // inputs change while a DUP is in flight; reserved opcode is what gets sampled next
    rq_d.delete(); rq_e.delete();
    cmd_valid = 1; cmd_op = 3'd4; cmd_data = 8'h99;
    @(posedge clk); #1 cmd_op = 3'd7; cmd_data = 8'(($urandom));
    repeat (3) begin @(posedge clk); #1 cmd_data = 8'($urandom); end
    @(posedge clk); #1 cmd_valid = 0;
    wait_idle();
    chk("hold_sp", sp, 2);
    if (rq_e.size() == 2) begin
      chk("hold_dup", rq_d[0], 'h3C); chk("hold_rsvd_err", rq_e[1], 1);
    end else chk("hold_cnt", rq_e.size(), 2);
    issue(6, 0); issue(6, 0);
    wait_idle();
    chk("drop_sp", sp, 0);
    // reset while SWAP is in WR0
    issue(1, 1); issue(1, 2);
    wait_idle();
    rq_d.delete();
    issue(5, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_sp", sp, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", rq_d.size(), 0);
    @(posedge clk); #1;
    // empty / full behaviour
    rq_d.delete(); rq_e.delete();
    issue(2, 0);
    wait_idle();
`ifdef STACK_CTRL_GUARD_EN
    chk("pop_empty_err", rq_e[$], 1);
    chk("pop_empty_sp", sp, 0);
    for (int i = 0; i <= DP; i++) issue(1, i);
    wait_idle();
    chk("overflow_err", rq_e[$], 1);
    chk("overflow_full", full, 1);
    chk("overflow_sp", sp, DP);
    repeat (DP) issue(6, 0);
    wait_idle();
    chk("drain_sp", sp, 0);
`else
    chk("pop_wrap_err", rq_e[$], 0);
    chk("pop_wrap_sp", sp, DP - 1);
    chk("pop_wrap_full", full, 0);
    issue(1, 'h42);
    wait_idle();
    chk("push_wrap_sp", sp, 0);
`endif
    // random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst = $urandom_range(0, 299) == 0;
      cmd_valid = $urandom_range(0, 3) != 0;
      cmd_op = $urandom_range(0, 3) == 0 ? 3'd1 : 3'($urandom_range(0, 7));
      cmd_data = 8'($urandom);
    end
    @(posedge clk); #1 rst = 0; cmd_valid = 0;
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
